// File: rtl/monitor_pkg.sv
// Shared types and byte constants for the UART memory monitor.
package monitor_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_HI,
    ST_A_LO,
    ST_D_HI,
    ST_D_LO,
    ST_MEM,
    ST_TX_SEND,
    ST_TX_GUARD,
    ST_TX_WAIT
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

endpackage

// File: rtl/uart_mem_monitor_if.sv
// Byte-stream (uart_rx/uart_tx) and SRAM req/ack signals seen by the monitor.
interface uart_mem_monitor_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_busy;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  rx_byte, rx_valid, tx_busy, mem_rdata, mem_ack,
    output tx_data, tx_send, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_byte, rx_valid, tx_busy, mem_rdata, mem_ack,
    input  tx_data, tx_send, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_mem_monitor.sv
// Host debug monitor: parses W/R byte commands, performs one SRAM access and
// streams the reply bytes into uart_tx.
module uart_mem_monitor
  import monitor_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_mem_monitor_if.master bus,
  output logic               active,
  output logic               overrun
);

  // An inter-byte gap longer than one second is clamped to one second.
  localparam int TMO_CYCLES = (TIMEOUT_CYCLES < CLK_FREQ) ? TIMEOUT_CYCLES : CLK_FREQ;
  localparam int TMR_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TMO_CYCLES);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_mem_we;
  logic [15:0]        r_addr;
  logic [15:0]        r_wdata;
  logic [7:0]         r_tx_data;
  logic [15:0]        r_rsp_buf;
  logic               r_rsp_idx;
  logic               r_rsp_two;
  logic [TMR_W-1:0]   r_timer;
  logic               r_overrun;

  logic               w_is_cmd;
  logic               w_collect;
  logic               w_expire;
  logic               w_ack_done;
  logic               w_err_load;
  logic               w_tx_next;
  logic               w_drop_state;
  logic               w_tx_send;
  logic               w_mem_req;
  logic [15:0]        w_rsp_val;

  assign w_is_cmd     = (bus.rx_byte == CMD_WR) || (bus.rx_byte == CMD_RD);
  assign w_collect    = (r_state == ST_A_HI) || (r_state == ST_A_LO) ||
                        (r_state == ST_D_HI) || (r_state == ST_D_LO);
  assign w_expire     = w_collect && !bus.rx_valid && (r_timer == TMR_ONE);
  assign w_ack_done   = (r_state == ST_MEM) && bus.mem_ack;
  assign w_err_load   = (r_state == ST_IDLE) && bus.rx_valid && !w_is_cmd;
  assign w_tx_next    = (r_state == ST_TX_WAIT) && !bus.tx_busy && r_rsp_two && !r_rsp_idx;
  assign w_drop_state = (r_state == ST_MEM) || (r_state == ST_TX_SEND) ||
                        (r_state == ST_TX_GUARD) || (r_state == ST_TX_WAIT);

  // Reply byte gi sits at [15-8*gi -: 8]; byte 0 is always sent first.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    assign w_rsp_val[15-8*gi -: 8] =
        (r_state == ST_IDLE) ? ((gi == 0) ? RSP_ERR : 8'h00) :
        r_mem_we             ? ((gi == 0) ? RSP_OK  : 8'h00) :
                               bus.mem_rdata[15-8*gi -: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_tx_send    = 1'b0;
    w_mem_req    = 1'b0;
    case (r_state)
      ST_IDLE:     if (bus.rx_valid) w_state_next = w_is_cmd ? ST_A_HI : ST_TX_SEND;
      ST_A_HI:     if (bus.rx_valid) w_state_next = ST_A_LO;
                   else if (w_expire) w_state_next = ST_IDLE;
      ST_A_LO:     if (bus.rx_valid) w_state_next = r_mem_we ? ST_D_HI : ST_MEM;
                   else if (w_expire) w_state_next = ST_IDLE;
      ST_D_HI:     if (bus.rx_valid) w_state_next = ST_D_LO;
                   else if (w_expire) w_state_next = ST_IDLE;
      ST_D_LO:     if (bus.rx_valid) w_state_next = ST_MEM;
                   else if (w_expire) w_state_next = ST_IDLE;
      ST_MEM: begin
        w_mem_req = 1'b1;
        if (bus.mem_ack) w_state_next = ST_TX_SEND;
      end
      ST_TX_SEND: begin
        if (!bus.tx_busy) begin
          w_tx_send    = 1'b1;
          w_state_next = ST_TX_GUARD;
        end
      end
      ST_TX_GUARD: w_state_next = ST_TX_WAIT;
      ST_TX_WAIT:  if (!bus.tx_busy) w_state_next = w_tx_next ? ST_TX_SEND : ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tx_data <= '0;
      r_rsp_buf <= '0;
      r_rsp_idx <= 1'b0;
      r_rsp_two <= 1'b0;
      r_timer   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && bus.rx_valid && w_is_cmd) begin
        r_mem_we <= (bus.rx_byte == CMD_WR);
        r_timer  <= TMR_LOAD;
      end else if (w_collect) begin
        if (bus.rx_valid)      r_timer <= TMR_LOAD;
        else if (r_timer != 0) r_timer <= r_timer - TMR_ONE;
      end

      if (bus.rx_valid) begin
        case (r_state)
          ST_A_HI: r_addr[15:8]  <= bus.rx_byte;
          ST_A_LO: r_addr[7:0]   <= bus.rx_byte;
          ST_D_HI: r_wdata[15:8] <= bus.rx_byte;
          ST_D_LO: r_wdata[7:0]  <= bus.rx_byte;
          default: ;
        endcase
      end

      if (w_ack_done || w_err_load) begin
        r_rsp_buf <= w_rsp_val;
        r_tx_data <= w_rsp_val[15:8];
        r_rsp_idx <= 1'b0;
        r_rsp_two <= w_ack_done && !r_mem_we;
      end else if (w_tx_next) begin
        r_rsp_idx <= 1'b1;
        r_tx_data <= r_rsp_buf[7:0];
      end

      if (bus.rx_valid && w_drop_state) r_overrun <= 1'b1;
    end
  end

  assign bus.tx_data   = r_tx_data;
  assign bus.tx_send   = w_tx_send;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign active        = (r_state != ST_IDLE);
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_uart_mem_monitor.sv
// Directed bench: command-level model of replies and SRAM accesses, checked
// every cycle against the monitor, plus literal spot checks.
module tb_uart_mem_monitor;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } mem_op_t;

  logic clk = 1'b0;
  logic rst_n;
  logic active;
  logic overrun;

  always #5 clk = ~clk;

  uart_mem_monitor_if bus();

  uart_mem_monitor #(
    .CLK_FREQ      (50_000_000),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.master),
    .active (active),
    .overrun(overrun)
  );

  int vectors     = 0;
  int miscompares = 0;

  mem_op_t     exp_mem[$];
  logic [7:0]  exp_tx[$];
  mem_op_t     mem_log[$];
  logic [7:0]  sent_log[$];
  logic [15:0] model_mem[logic [15:0]];
  logic [15:0] sram[logic [15:0]];

  int ack_delay  = 0;
  int busy_len   = 2;
  bit force_busy = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  // uart_tx stand-in: busy for busy_len cycles after each send.
  initial begin
    int cnt  = 0;
    int seen = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (sent_log.size() != seen) begin
        seen = sent_log.size();
        cnt  = busy_len;
      end
      bus.tx_busy = force_busy || (cnt != 0);
      if (cnt != 0) cnt--;
    end
  end

  // SRAM stand-in: ack after ack_delay request cycles.
  initial begin
    int w = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req === 1'b1) begin
        if (w >= ack_delay) begin
          bus.mem_ack = 1'b1;
          w = 0;
          if (bus.mem_we) sram[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = sram.exists(bus.mem_addr) ? sram[bus.mem_addr] : 16'h0000;
        end else begin
          w++;
        end
      end else begin
        w = 0;
      end
    end
  end

  // Per-cycle compare against the command-level expectations.
  initial begin
    int      since_send = 100;
    logic    prev_req   = 1'b0;
    mem_op_t cur;
    mem_op_t e;
    cur = '0;
    forever begin
      @(negedge clk);
      #2;
      since_send++;
      if (bus.tx_send === 1'b1) begin
        check("send_busy_low", bus.tx_busy, 1'b0);
        check("send_spacing", since_send >= 2, 1'b1);
        since_send = 0;
        sent_log.push_back(bus.tx_data);
        check("send_expected", exp_tx.size() != 0, 1'b1);
        if (exp_tx.size() != 0) check("tx_byte", bus.tx_data, exp_tx.pop_front());
      end
      if (bus.mem_req === 1'b1 && !prev_req) begin
        cur = '{bus.mem_we, bus.mem_addr, bus.mem_wdata};
        mem_log.push_back(cur);
        check("req_expected", exp_mem.size() != 0, 1'b1);
        if (exp_mem.size() != 0) begin
          e = exp_mem.pop_front();
          check("req_we", bus.mem_we, e.we);
          check("req_addr", bus.mem_addr, e.addr);
          if (e.we) check("req_wdata", bus.mem_wdata, e.data);
        end
      end else if (bus.mem_req === 1'b1) begin
        check("req_stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, cur);
      end
      prev_req = bus.mem_req;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic cmd_write(input logic [15:0] addr, input logic [15:0] data);
    $display("cmd W addr=%h data=%h", addr, data);
    exp_mem.push_back('{1'b1, addr, data});
    exp_tx.push_back(8'h4B);
    model_mem[addr] = data;
    send_byte(8'h57); send_byte(addr[15:8]); send_byte(addr[7:0]);
    send_byte(data[15:8]); send_byte(data[7:0]);
  endtask

  task automatic cmd_read(input logic [15:0] addr);
    logic [15:0] d;
    d = model_mem.exists(addr) ? model_mem[addr] : 16'h0000;
    $display("cmd R addr=%h expect=%h", addr, d);
    exp_mem.push_back('{1'b0, addr, 16'h0000});
    exp_tx.push_back(d[15:8]);
    exp_tx.push_back(d[7:0]);
    send_byte(8'h52); send_byte(addr[15:8]); send_byte(addr[7:0]);
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      #3;
      if (!active && exp_tx.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("reply_done_in_time", ok, 1'b1);
  endtask

  initial begin
    int  n;
    bit  found;
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    sram[16'h0000]      = 16'hA5C3;
    model_mem[16'h0000] = 16'hA5C3;

    repeat (3) @(negedge clk);
    #2;
    check("rst_tx_send", bus.tx_send, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);
    check("rst_mem_wdata", bus.mem_wdata, 16'h0000);
    check("rst_active", active, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write, ack three cycles after the request rises
    ack_delay = 3; busy_len = 2;
    cmd_write(16'h1234, 16'hBEEF);
    wait_idle(100);
    check("wr_reply_count", sent_log.size(), 1);
    check("wr_reply_byte", sent_log[0], 8'h4B);
    check("wr_addr", mem_log[0].addr, 16'h1234);
    check("wr_wdata", mem_log[0].data, 16'hBEEF);
    check("wr_we", mem_log[0].we, 1'b1);

    // Read back with zero-wait ack and a long busy period
    ack_delay = 0; busy_len = 5;
    cmd_read(16'h1234);
    wait_idle(100);
    check("rd_byte_hi", sent_log[1], 8'hBE);
    check("rd_byte_lo", sent_log[2], 8'hEF);
    check("rd_we", mem_log[1].we, 1'b0);

    // Unknown opcode
    $display("cmd ? byte=41");
    exp_tx.push_back(8'h3F);
    send_byte(8'h41);
    wait_idle(100);
    check("unk_reply", sent_log[3], 8'h3F);
    check("unk_no_req", mem_log.size(), 2);

    // Timeout: last byte, then 100 silent cycles still active, 101st idle
    $display("cmd W truncated after addr_hi");
    send_byte(8'h57); send_byte(8'h12);
    repeat (99) @(negedge clk);
    #2;
    check("tmo_still_active", active, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    check("tmo_back_idle", active, 1'b0);
    check("tmo_no_req", mem_log.size(), 2);
    check("tmo_no_reply", sent_log.size(), 4);
    cmd_read(16'h0000);
    wait_idle(100);
    check("post_tmo_hi", sent_log[4], 8'hA5);
    check("post_tmo_lo", sent_log[5], 8'hC3);

    // Overrun: a byte lands while the reply is in TX_WAIT
    check("ovr_clear_before", overrun, 1'b0);
    ack_delay = 2; busy_len = 3;
    n = sent_log.size();
    cmd_read(16'h1234);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #3;
      if (sent_log.size() > n) begin
        found = 1'b1;
        break;
      end
    end
    check("ovr_first_send_seen", found, 1'b1);
    @(negedge clk);
    @(negedge clk);
    force_busy   = 1'b1;
    bus.rx_byte  = 8'hAA;
    bus.rx_valid = 1'b1;
    $display("inject byte=AA during reply");
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    check("ovr_set", overrun, 1'b1);
    force_busy = 1'b0;
    wait_idle(100);
    check("ovr_reply_hi", sent_log[6], 8'hBE);
    check("ovr_reply_lo", sent_log[7], 8'hEF);
    check("ovr_sticky", overrun, 1'b1);

    // Reset while the read request is outstanding
    ack_delay = 20; busy_len = 2;
    n = sent_log.size();
    cmd_read(16'h0000);
    for (int i = 0; i < 50; i++) begin
      if (bus.mem_req === 1'b1) break;
      @(negedge clk);
      #2;
    end
    check("rst_req_seen", bus.mem_req, 1'b1);
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b0;
    $display("reset asserted mid-read");
    exp_tx.delete();
    #1;
    check("mid_rst_mem_req", bus.mem_req, 1'b0);
    check("mid_rst_tx_send", bus.tx_send, 1'b0);
    check("mid_rst_active", active, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    check("mid_rst_mem_we", bus.mem_we, 1'b0);
    check("mid_rst_mem_addr", bus.mem_addr, 16'h0000);
    check("mid_rst_mem_wdata", bus.mem_wdata, 16'h0000);
    check("mid_rst_tx_data", bus.tx_data, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #2;
    check("post_rst_no_reply", sent_log.size(), n);
    check("post_rst_idle", active, 1'b0);

    check("all_reqs_seen", exp_mem.size(), 0);
    check("all_replies_seen", exp_tx.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_mem_monitor.md
# uart_mem_monitor

Host-side debug controller between the `uart_rx`/`uart_tx` byte datapaths and the board SRAM port. It parses a byte-serial command stream from the host, issues single 16-bit SRAM reads and writes through a req/ack memory port, and sequences the response bytes into `uart_tx` using that block's send/busy handshake. It sits in the top level on `clk_50` and replaces ad-hoc UART heartbeat logic as the host's path to iAPX432 memory images.

## Interface
- `CLK_FREQ`, 50_000_000, clock frequency in Hz; sizes the timeout counter.
- `TIMEOUT_CYCLES`, 5_000_000, allowed inter-byte gap inside a command (100 ms at 50 MHz).
- `clk`  in  1  system clock (`clk_50`); the block uses this single clock only.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_byte`  in  8  received byte from `uart_rx`.
- `rx_valid`  in  1  one-cycle strobe; `rx_byte` is valid on this cycle.
- `tx_data`  out  8  byte to `uart_tx` `data_in`.
- `tx_send`  out  1  one-cycle send strobe to `uart_tx`.
- `tx_busy`  in  1  `uart_tx` busy.
- `mem_req`  out  1  memory request, level.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  16  word address.
- `mem_wdata`  out  16  write data.
- `mem_rdata`  in  16  read data; sampled on the `mem_ack` cycle.
- `mem_ack`  in  1  one-cycle completion strobe.
- `active`  out  1  high in any state other than IDLE.
- `overrun`  out  1  sticky; set when a byte is dropped; cleared only by reset.

## Operation
- Commands are big-endian.
- `0x57` ('W') is followed by addr_hi, addr_lo, data_hi and data_lo. The block performs a write and replies `0x4B` ('K').
- `0x52` ('R') is followed by addr_hi and addr_lo. The block performs a read and replies data_hi then data_lo.
- Any other byte received in IDLE gets the reply `0x3F` ('?'). No memory access occurs.
- States:
  - IDLE: on `0x57` go to A_HI with `mem_we`=1. On `0x52` go to A_HI with `mem_we`=0. On any other byte, load `0x3F` into the response buffer and go to TX_SEND.
  - A_HI → A_LO → (D_HI → D_LO if write) → MEM: each state advances on `rx_valid` and latches the byte into `mem_addr` or `mem_wdata`.
  - MEM: `mem_req`=1 with address, write data and `mem_we` held stable until `mem_ack`.
    - On ack, load the response buffer and go to TX_SEND.
    - For a write, the buffer holds 1 byte (`0x4B`).
    - For a read, it holds 2 bytes from `mem_rdata`: [15:8] first, then [7:0].
  - TX_SEND: wait for `tx_busy`=0, then pulse `tx_send` for 1 cycle with the current byte and go to TX_GUARD.
  - TX_GUARD: 1 fixed cycle that absorbs `uart_tx`'s busy-rise latency, then go to TX_WAIT.
  - TX_WAIT: wait for `tx_busy`=0. If bytes remain, go to TX_SEND; otherwise go to IDLE.
- Timeout: in A_HI, A_LO, D_HI and D_LO, a counter reloads on every `rx_valid`. If `TIMEOUT_CYCLES` cycles pass with no byte, return to IDLE silently with no memory access and no reply. The counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- A byte arriving in MEM, TX_SEND, TX_GUARD or TX_WAIT is discarded and sets `overrun`. The state is not disturbed.
- `mem_ack` outside MEM is ignored.

## Timing
- Reset values:
  - state is IDLE.
  - `tx_send`, `mem_req`, `mem_we`, `overrun` are 0.
  - `tx_data`, `mem_addr`, `mem_wdata` are 0.
  - the timeout counter is 0.
  - `active` is 0.
- Reset is honoured mid-operation: `mem_req` drops asynchronously, and any command in progress is abandoned.
- `mem_req` rises on the cycle after the last command byte's `rx_valid`. It falls on the cycle after `mem_ack`.
- A zero-wait `mem_ack` (ack on the first req cycle) is legal.
- The first `tx_send` occurs no earlier than 1 cycle after the `mem_ack` cycle.
- Consecutive response bytes are separated by at least TX_GUARD plus the busy period.
- `tx_data` is stable from the `tx_send` cycle until the next TX_SEND.
- If `rx_valid` and a timeout expiry occur in the same cycle, the byte wins and the counter reloads.

## Structure
- Shared package `monitor_pkg`:
  - state enum.
  - opcode constants `CMD_WR`=0x57, `CMD_RD`=0x52.
  - reply constants `RSP_OK`=0x4B, `RSP_ERR`=0x3F.
- The block is one module. The response sequencer is a 2-entry byte buffer plus a 1-bit index, kept inline; no sub-module.

## Test plan
- Write: send 57 12 34 BE EF.
  - `mem_req` rises with `mem_we`=1, addr 0x1234, wdata 0xBEEF.
  - Ack after 3 cycles produces exactly one `tx_send` with 0x4B.
- Read: send 52 12 34 with `mem_rdata`=0xBEEF on a zero-wait ack.
  - The block sends 0xBE then 0xEF.
  - Each `tx_send` is issued only with `tx_busy` low, and the two are at least 2 cycles apart.
- Unknown opcode 0x41 → single reply 0x3F; `mem_req` never asserts.
- Timeout, with `TIMEOUT_CYCLES`=100:
  - Send 57 12, then idle for 101 cycles. The block returns to IDLE with no `mem_req` and no reply.
  - A following 52 00 00 then executes normally.
- Overrun: inject a byte while in TX_WAIT (`tx_busy` held high).
  - `overrun`=1; the reply completes correctly.
  - The block then returns to IDLE.
- Reset mid-read: assert `rst_n`=0 while `mem_req`=1. All outputs go to their reset values immediately, and no reply is sent after release.
